// File: rtl/regfile_dump_reader.sv
// -----------------------------------------------------------------------------
// regfile_dump_reader
//
// Sequential read-out engine for the 8x16 register file. A start request
// latches a first address and a count (0 means a full dump of NUM_REGS). The
// engine then walks the addresses through one combinational read port,
// wrapping modulo NUM_REGS. Each value is streamed, tagged with the address it
// came from, over a valid/ready channel.
//
// Optional feature macro: REGDUMP_CHECKSUM_EN
//   When defined, one extra beat follows the last register beat. That beat
//   carries the XOR of every emitted data word, with address 0, and it is the
//   only beat with last set. Busy and done shift back by that one beat.
//
// Ports:
//   clk_i        clock, all state updates on the rising edge
//   rst_ni       asynchronous active-low reset
//   start_i      one-cycle dump request, sampled only while idle
//   first_reg_i  first register address of the dump
//   count_i      number of registers to dump (0 = NUM_REGS)
//   abort_i      cancel a dump in progress (drops the in-flight beat)
//   reg_addr_o   address to the register-file read port
//   reg_data_i   combinational read data for reg_addr_o
//   out_valid_o  output beat valid
//   out_ready_i  consumer accepts the beat
//   out_data_o   captured register value (or checksum)
//   out_addr_o   address out_data_o was read from
//   out_last_o   final beat of the dump
//   busy_o       high whenever the engine is not idle
//   done_o       one-cycle pulse after the final beat is accepted
// -----------------------------------------------------------------------------
module regfile_dump_reader #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] first_reg_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              abort_i,
  output logic [ADDR_W-1:0] reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [ADDR_W-1:0] out_addr_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int CNT_W = ADDR_W + 1;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0]  NUM_CNT  = CNT_W'(NUM_REGS);
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              csum_sent_q, csum_sent_d;

  logic              hs_s;
  logic              final_hs_s;
  logic              capture_s;
  logic [ADDR_W-1:0] ptr_inc_s;

  // Handshake decode shared by the FSM and the datapath.
  always_comb begin
    hs_s = valid_q & out_ready_i;
    // With the checksum enabled, the dump ends only after the checksum beat.
    if (CSUM_EN) begin
      final_hs_s = hs_s & (rem_q == CNT_ZERO) & csum_sent_q;
    end else begin
      final_hs_s = hs_s & (rem_q == CNT_ZERO);
    end
    // A register is captured in FETCH, and in SEND when the current beat
    // leaves and registers remain; abort suppresses both.
    if (abort_i) begin
      capture_s = 1'b0;
    end else if (state_q == ST_FETCH) begin
      capture_s = 1'b1;
    end else if (state_q == ST_SEND) begin
      capture_s = hs_s & (rem_q != CNT_ZERO);
    end else begin
      capture_s = 1'b0;
    end
    // Pointer increment wraps modulo NUM_REGS, which need not be a power of two.
    if (ptr_q == PTR_LAST) begin
      ptr_inc_s = PTR_ZERO;
    end else begin
      ptr_inc_s = ptr_q + PTR_ONE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      ptr_q       <= PTR_ZERO;
      rem_q       <= CNT_ZERO;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= DATA_ZERO;
      addr_q      <= PTR_ZERO;
      done_q      <= 1'b0;
      acc_q       <= DATA_ZERO;
      csum_sent_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      done_q      <= done_d;
      acc_q       <= acc_d;
      csum_sent_q <= csum_sent_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (final_hs_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_SEND;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: capture, checksum beat, completion and abort.
  always_comb begin
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    addr_d      = addr_q;
    done_d      = 1'b0;
    acc_d       = acc_q;
    csum_sent_d = csum_sent_q;
    if (state_q == ST_IDLE) begin
      if (start_i) begin
        ptr_d       = first_reg_i;
        rem_d       = (count_i == CNT_ZERO) ? NUM_CNT : count_i;
        acc_d       = DATA_ZERO;
        csum_sent_d = 1'b0;
      end else begin
        ptr_d = ptr_q;
      end
    end else if (abort_i) begin
      valid_d     = 1'b0;
      last_d      = 1'b0;
      acc_d       = DATA_ZERO;
      csum_sent_d = 1'b0;
    end else if (capture_s) begin
      data_d  = reg_data_i;
      addr_d  = ptr_q;
      valid_d = 1'b1;
      // Register beats never carry last when a checksum beat follows.
      last_d  = (CSUM_EN) ? 1'b0 : (rem_q == CNT_ONE);
      ptr_d   = ptr_inc_s;
      rem_d   = rem_q - CNT_ONE;
      acc_d   = acc_q ^ reg_data_i;
    end else if (state_q == ST_SEND && hs_s && CSUM_EN && !csum_sent_q) begin
      // Registers exhausted: emit the accumulated checksum as the last beat.
      data_d      = acc_q;
      addr_d      = PTR_ZERO;
      valid_d     = 1'b1;
      last_d      = 1'b1;
      csum_sent_d = 1'b1;
    end else if (final_hs_s) begin
      valid_d     = 1'b0;
      last_d      = 1'b0;
      done_d      = 1'b1;
      acc_d       = DATA_ZERO;
      csum_sent_d = 1'b0;
    end else begin
      // Stalled: hold the beat stable until the consumer accepts it.
      valid_d = valid_q;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    reg_addr_o  = ptr_q;
    out_valid_o = valid_q;
    out_data_o  = data_q;
    out_addr_o  = addr_q;
    out_last_o  = last_q;
    busy_o      = (state_q != ST_IDLE);
    done_o      = done_q;
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam int CSUM = 1;
`else
  localparam int CSUM = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  first_reg;
  logic [3:0]  count;
  logic        abort;
  logic [2:0]  reg_addr;
  logic [15:0] reg_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [2:0]  out_addr;
  logic        out_last;
  logic        busy;
  logic        done;

  logic [15:0] rf [8];
  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] first;
    logic [3:0] cnt;
    int         exp_n;
  } vec_t;

  vec_t vecs [6];
  logic pat [4];

  regfile_dump_reader dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .first_reg_i (first_reg),
    .count_i     (count),
    .abort_i     (abort),
    .reg_addr_o  (reg_addr),
    .reg_data_i  (reg_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_addr_o  (out_addr),
    .out_last_o  (out_last),
    .busy_o      (busy),
    .done_o      (done)
  );

  assign reg_data = rf[reg_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_busy"},  {31'd0, busy},      32'd0);
    chk({tag, "_done"},  {31'd0, done},      32'd0);
  endtask

  // One complete dump; the expected stream is derived from first/exp_n here.
  task automatic do_dump(input logic [2:0] first, input logic [3:0] cnt,
                         input int exp_n, input bit stall);
    int total;
    int j;
    int cyc;
    logic [15:0] acc;
    logic [2:0]  ea;
    logic [15:0] ed;
    logic        el;
    total = exp_n + CSUM;
    j = 0;
    cyc = 0;
    acc = 16'h0000;
    @(negedge clk);
    start = 1'b1; first_reg = first; count = cnt; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("fetch_busy",  {31'd0, busy},      32'd1);
    chk("fetch_raddr", {29'd0, reg_addr},  {29'd0, first});
    chk("fetch_valid", {31'd0, out_valid}, 32'd0);
    if (stall) begin
      // A start request while busy must be ignored.
      start = 1'b1; first_reg = 3'd5; count = 4'd1;
    end
    @(negedge clk);
    while (j < total && cyc < 60) begin
      if (stall) out_ready = pat[cyc % 4];
      if (j < exp_n) begin
        ea = first + j[2:0];
        ed = 16'h1111 * {13'd0, ea};
        el = (CSUM == 0) && (j == exp_n - 1);
      end else begin
        ea = 3'd0;
        ed = acc;
        el = 1'b1;
      end
      chk("beat_valid", {31'd0, out_valid}, 32'd1);
      chk("beat_data",  {16'd0, out_data},  {16'd0, ed});
      chk("beat_addr",  {29'd0, out_addr},  {29'd0, ea});
      chk("beat_last",  {31'd0, out_last},  {31'd0, el});
      chk("beat_busy",  {31'd0, busy},      32'd1);
      if (out_valid && out_ready) begin
        if (j < exp_n) acc = acc ^ ed;
        j++;
      end
      cyc++;
      @(negedge clk);
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("beats_total", j, total);
    if (!stall) chk("beats_cycles", cyc, total);
    chk("done_pulse", {31'd0, done},      32'd1);
    chk("done_busy",  {31'd0, busy},      32'd0);
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    chk("done_clear", {31'd0, done}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) rf[i] = 16'h1111 * i[15:0];
    vecs[0] = '{first: 3'd0, cnt: 4'd0, exp_n: 8};
    vecs[1] = '{first: 3'd6, cnt: 4'd3, exp_n: 3};
    vecs[2] = '{first: 3'd6, cnt: 4'd4, exp_n: 4};
    vecs[3] = '{first: 3'd1, cnt: 4'd2, exp_n: 2};
    vecs[4] = '{first: 3'd7, cnt: 4'd1, exp_n: 1};
    vecs[5] = '{first: 3'd3, cnt: 4'd8, exp_n: 8};
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;

    rst_n = 1'b0; start = 1'b0; first_reg = 3'd0; count = 4'd0;
    abort = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk_idle("rst");
    chk("rst_data",  {16'd0, out_data}, 32'd0);
    chk("rst_addr",  {29'd0, out_addr}, 32'd0);
    chk("rst_raddr", {29'd0, reg_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("post_rst");

    // Table of full-throughput dumps
    for (int v = 0; v < 6; v++) begin
      do_dump(vecs[v].first, vecs[v].cnt, vecs[v].exp_n, 1'b0);
    end

    // Backpressure with ready 1-0-0-1 and an ignored start while busy
    do_dump(3'd2, 4'd5, 5, 1'b1);

    // Abort on the 2nd beat of an 8-register dump
    @(negedge clk);
    start = 1'b1; first_reg = 3'd0; count = 4'd0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("abort_b0_addr", {29'd0, out_addr}, 32'd0);
    @(negedge clk);
    chk("abort_b1_addr", {29'd0, out_addr}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort");
    @(negedge clk);
    chk("abort_nodone", {31'd0, done}, 32'd0);
    do_dump(3'd2, 4'd3, 3, 1'b0);

    // Asynchronous reset mid-dump
    @(negedge clk);
    start = 1'b1; first_reg = 3'd4; count = 4'd0;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("arst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle("arst");
    chk("arst_data", {16'd0, out_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_idle("arst_rel");
    do_dump(3'd5, 4'd4, 4, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_dump_reader.md
# regfile_dump_reader

Sequential read-out engine for the 8×16-bit register file: on a start pulse it walks a programmable range of register addresses through one register-file read port. It streams each value, tagged with its address, over a valid/ready output channel. It sits beside the datapath as the debug/trace consumer of the register file, the reader counterpart to the write-back path that fills it.

## Interface
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, number of registers; address arithmetic wraps modulo NUM_REGS

Ports:
- Clock  in  1  single clock; all state updates on rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Start  in  1  one-cycle request; sampled only in IDLE
- FirstReg  in  ADDR_W  first register address of the dump
- Count  in  ADDR_W+1  number of registers to dump; 0 is treated as NUM_REGS
- Abort  in  1  cancel dump in progress
- RegAddr  out  ADDR_W  address driven to the register-file read port
- RegData  in  DATA_W  combinational read data for RegAddr
- OutValid  out  1  output beat valid
- OutReady  in  1  consumer accepts beat
- OutData  out  DATA_W  captured register value
- OutAddr  out  ADDR_W  address OutData was read from
- OutLast  out  1  marks final beat of dump
- Busy  out  1  high in any state other than IDLE
- Done  out  1  one-cycle pulse after final beat is accepted

## Operation
- States: IDLE, FETCH, SEND.
- IDLE:
  - Start=1 → latch FirstReg into the address pointer and Count into remaining (0→NUM_REGS); go to FETCH.
- FETCH:
  - RegAddr = pointer.
  - At the next edge: OutData←RegData, OutAddr←pointer, OutValid←1, OutLast←(remaining==1); pointer←pointer+1 mod NUM_REGS; remaining←remaining−1; go to SEND.
- SEND:
  - RegAddr = pointer, the next register to capture.
  - OutValid && OutReady with remaining>0 → capture the next beat as in FETCH; OutValid stays 1 (back-to-back).
  - Handshake with remaining==0 → OutValid←0, Done pulses for 1 cycle, go to IDLE.
  - No handshake → OutData, OutAddr and OutLast are held stable.
- Start while Busy is ignored.
- Abort has priority over everything in FETCH/SEND. The next edge forces IDLE with OutValid=0 and OutLast=0; Done is not pulsed and the in-flight beat is dropped.
- Data is sampled at the capture edge. Register-file writes that land before that edge are visible; no snapshot consistency is provided across the dump.
- Address wrap example: FirstReg=6, Count=4 → addresses 6,7,0,1.

## Timing
- Reset values: OutValid=0, OutLast=0, Busy=0, Done=0, OutData=0, OutAddr=0, RegAddr=0, state=IDLE.
- Start sampled at edge N → RegAddr=FirstReg during cycle N+1 → first beat valid after edge N+1.
- Throughput: 1 beat/cycle with OutReady held high; a dump of k registers occupies k+1 cycles of Busy, plus the Done cycle.
- Done is asserted in the cycle after the final handshake; Busy=0 in that same cycle; a new Start is accepted in that cycle.
- Reset_n asserted mid-dump clears all state immediately, asynchronously; no Done is produced.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - After the last register beat, one extra beat is emitted: OutData = XOR of all emitted data words, OutAddr=0, OutLast=1 on this beat only.
  - Busy and Done shift by one beat.
  - Abort clears the accumulator.
- Undefined: no checksum beat; OutLast is set on the final register beat.

## Test plan
- Reset: regs hold 0x1111·i; release Reset_n → all outputs 0, Busy=0.
- FirstReg=0, Count=0, OutReady=1 → 8 consecutive beats: addr 0..7, data 0x0000..0x7777; OutLast on addr 7; Done 1 cycle after.
- FirstReg=6, Count=3 → addrs 6,7,0, data 0x6666,0x7777,0x0000; wrap verified.
- OutReady toggled 1-0-0-1 during dump → OutData/OutAddr stable while stalled; no beat lost or duplicated.
- Abort asserted on 2nd beat of an 8-register dump → OutValid=0 next cycle, no Done; a new Start then dumps correctly.
- REGDUMP_CHECKSUM_EN, FirstReg=1, Count=2 → beats 0x1111, 0x2222, then 0x3333 with OutLast=1.
